// File: rtl/fetch_pc_if.sv
// ============================================================================
// Module      : fetch_pc_if
// Description : Redirect, return-stack and PC status bundle of the fetch PC unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fetch_pc_if #(
    parameter int ADDR_W    = 32,
    parameter int RAS_DEPTH = 4
);
    logic                         stall;
    logic                         exc_req;
    logic                         eret_req;
    logic [ADDR_W-3:0]            epc;
    logic                         jr_req;
    logic [ADDR_W-1:0]            jr_target;
    logic                         j_req;
    logic [25:0]                  j_addr26;
    logic                         br_taken;
    logic [15:0]                  br_off16;
    logic                         ras_push;
    logic                         ras_pop;
    logic [ADDR_W-1:0]            pc;
    logic [ADDR_W-1:0]            npc;
    logic                         halted;
    logic                         pend_valid;
    logic                         misaligned;
    logic [ADDR_W-1:0]            ras_top;
    logic                         ras_empty;
    logic [$clog2(RAS_DEPTH):0]   ras_count;

    modport master (
        output stall, exc_req, eret_req, epc, jr_req, jr_target,
               j_req, j_addr26, br_taken, br_off16, ras_push, ras_pop,
        input  pc, npc, halted, pend_valid, misaligned,
               ras_top, ras_empty, ras_count
    );

    modport slave (
        input  stall, exc_req, eret_req, epc, jr_req, jr_target,
               j_req, j_addr26, br_taken, br_off16, ras_push, ras_pop,
        output pc, npc, halted, pend_valid, misaligned,
               ras_top, ras_empty, ras_count
    );
endinterface

`default_nettype wire

// File: rtl/fetch_pc_unit.sv
// ============================================================================
// Module      : fetch_pc_unit
// Description : Fetch PC sequencer with prioritised redirects, stall-time
//               pending redirect capture and a circular return-address stack.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_pc_unit #(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(32'h0000_3000),
    parameter logic [ADDR_W-1:0] KTEXT_VEC = ADDR_W'(32'h0000_4180),
    parameter logic [ADDR_W-1:0] HALT_ADDR = KTEXT_VEC - ADDR_W'(4),
    parameter int                RAS_DEPTH = 4
) (
    input  wire logic  clk,
    input  wire logic  reset,
    fetch_pc_if.slave  bus
);

    localparam int c_PTR_W = $clog2(RAS_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    // Priority class: larger value wins
    localparam logic [2:0] c_CLS_NONE = 3'd0;
    localparam logic [2:0] c_CLS_BR   = 3'd1;
    localparam logic [2:0] c_CLS_J    = 3'd2;
    localparam logic [2:0] c_CLS_JR   = 3'd3;
    localparam logic [2:0] c_CLS_ERET = 3'd4;
    localparam logic [2:0] c_CLS_EXC  = 3'd5;

    logic [ADDR_W-1:0]  r_pc;
    logic               r_pend_valid;
    logic [2:0]         r_pend_cls;
    logic [ADDR_W-1:0]  r_pend_tgt;
    logic [ADDR_W-1:0]  r_ras [RAS_DEPTH];
    logic [c_PTR_W-1:0] r_top;
    logic [c_CNT_W-1:0] r_cnt;

    logic [ADDR_W-1:0]  w_seq;
    logic [ADDR_W-1:0]  w_br_tgt;
    logic [ADDR_W-1:0]  w_j_tgt;
    logic [2:0]         w_live_cls;
    logic [ADDR_W-1:0]  w_live_tgt;
    logic [ADDR_W-1:0]  w_npc;
    logic               w_halted;
    logic               w_pend_take;
    logic               w_latch;
    logic               w_push;
    logic               w_pop;
    logic               w_empty;

    assign w_seq    = r_pc + ADDR_W'(4);
    assign w_br_tgt = r_pc + {{(ADDR_W-18){bus.br_off16[15]}}, bus.br_off16, 2'b00};
    assign w_j_tgt  = {r_pc[ADDR_W-1:28], bus.j_addr26, 2'b00};
    assign w_halted = (r_pc == HALT_ADDR);

    always_comb begin
        w_live_cls = c_CLS_NONE;
        w_live_tgt = w_seq;
        if (bus.exc_req) begin
            w_live_cls = c_CLS_EXC;
            w_live_tgt = KTEXT_VEC;
        end else if (bus.eret_req) begin
            w_live_cls = c_CLS_ERET;
            w_live_tgt = {bus.epc, 2'b00};
        end else if (bus.jr_req) begin
            w_live_cls = c_CLS_JR;
            w_live_tgt = bus.jr_target;
        end else if (bus.j_req) begin
            w_live_cls = c_CLS_J;
            w_live_tgt = w_j_tgt;
        end else if (bus.br_taken) begin
            w_live_cls = c_CLS_BR;
            w_live_tgt = w_br_tgt;
        end
    end

    // Pending redirect wins ties against a live request of the same class
    assign w_pend_take = r_pend_valid && (r_pend_cls >= w_live_cls);
    assign w_latch     = bus.stall && !w_halted && (w_live_cls != c_CLS_NONE) &&
                         (!r_pend_valid || (w_live_cls >= r_pend_cls));

    always_comb begin
        w_npc = w_live_tgt;
        if (w_halted || bus.stall) begin
            w_npc = r_pc;
        end else if (w_pend_take) begin
            w_npc = r_pend_tgt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc         <= RESET_VEC;
            r_pend_valid <= 1'b0;
            r_pend_cls   <= c_CLS_NONE;
            r_pend_tgt   <= '0;
        end else begin
            r_pc <= w_npc;
            if (w_halted || !bus.stall) begin
                r_pend_valid <= 1'b0;
                r_pend_cls   <= c_CLS_NONE;
            end else if (w_latch) begin
                r_pend_valid <= 1'b1;
                r_pend_cls   <= w_live_cls;
                r_pend_tgt   <= w_live_tgt;
            end
        end
    end

    // Return-address stack keeps tracking decode even while fetch is stalled
    assign w_push  = bus.ras_push && !w_halted;
    assign w_pop   = bus.ras_pop  && !w_halted;
    assign w_empty = (r_cnt == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < RAS_DEPTH; i++) begin
                r_ras[i] <= '0;
            end
            r_top <= '0;
            r_cnt <= '0;
        end else if (w_push && (!w_pop || w_empty)) begin
            r_ras[r_top + c_PTR_W'(1)] <= w_seq;
            r_top <= r_top + c_PTR_W'(1);
            if (r_cnt != c_CNT_W'(RAS_DEPTH)) begin
                r_cnt <= r_cnt + c_CNT_W'(1);
            end
        end else if (w_push && w_pop) begin
            r_ras[r_top] <= w_seq;
        end else if (w_pop && !w_empty) begin
            r_top <= r_top - c_PTR_W'(1);
            r_cnt <= r_cnt - c_CNT_W'(1);
        end
    end

    assign bus.pc         = r_pc;
    assign bus.npc        = w_npc;
    assign bus.halted     = w_halted;
    assign bus.pend_valid = r_pend_valid;
    assign bus.misaligned = |r_pc[1:0];
    assign bus.ras_top    = w_empty ? '0 : r_ras[r_top];
    assign bus.ras_empty  = w_empty;
    assign bus.ras_count  = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_fetch_pc_unit.sv
// ============================================================================
// Module      : tb_fetch_pc_unit
// Description : Directed self-checking bench for fetch_pc_unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_pc_unit;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    fetch_pc_if #(.ADDR_W(32), .RAS_DEPTH(4)) bus ();

    fetch_pc_unit #(
        .ADDR_W    (32),
        .RESET_VEC (32'h0000_3000),
        .KTEXT_VEC (32'h0000_4180),
        .HALT_ADDR (32'h0000_417C),
        .RAS_DEPTH (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        bus.stall     = 1'b0;
        bus.exc_req   = 1'b0;
        bus.eret_req  = 1'b0;
        bus.epc       = '0;
        bus.jr_req    = 1'b0;
        bus.jr_target = '0;
        bus.j_req     = 1'b0;
        bus.j_addr26  = '0;
        bus.br_taken  = 1'b0;
        bus.br_off16  = '0;
        bus.ras_push  = 1'b0;
        bus.ras_pop   = 1'b0;
    endtask

    task automatic test_reset();
        clr();
        reset = 1'b0;
        #12;
        total++; if (bus.pc !== 32'h3000) begin bad++; $display("FAIL reset_pc: got %h want %h", bus.pc, 32'h3000); end
        total++; if (bus.pend_valid !== 1'b0) begin bad++; $display("FAIL reset_pend: got %b want 0", bus.pend_valid); end
        total++; if (bus.ras_count !== 3'd0) begin bad++; $display("FAIL reset_cnt: got %0d want 0", bus.ras_count); end
        total++; if (bus.ras_empty !== 1'b1) begin bad++; $display("FAIL reset_empty: got %b want 1", bus.ras_empty); end
        total++; if (bus.ras_top !== 32'h0) begin bad++; $display("FAIL reset_top: got %h want 0", bus.ras_top); end
        total++; if (bus.halted !== 1'b0) begin bad++; $display("FAIL reset_halted: got %b want 0", bus.halted); end
        reset = 1'b1;
        #1;
        total++; if (bus.npc !== 32'h3004) begin bad++; $display("FAIL reset_npc: got %h want %h", bus.npc, 32'h3004); end
    endtask

    task automatic test_sequential();
        logic [31:0] exp [3] = '{32'h3004, 32'h3008, 32'h300C};
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (bus.pc !== exp[i]) begin bad++; $display("FAIL seq_pc%0d: got %h want %h", i, bus.pc, exp[i]); end
        end
        tick();
    endtask

    task automatic test_branch_jump();
        total++; if (bus.pc !== 32'h3010) begin bad++; $display("FAIL br_start: got %h want %h", bus.pc, 32'h3010); end
        bus.br_taken = 1'b1; bus.br_off16 = 16'hFFFC;
        #1;
        total++; if (bus.npc !== 32'h3000) begin bad++; $display("FAIL br_npc: got %h want %h", bus.npc, 32'h3000); end
        tick();
        total++; if (bus.pc !== 32'h3000) begin bad++; $display("FAIL br_pc: got %h want %h", bus.pc, 32'h3000); end
        bus.j_req = 1'b1; bus.j_addr26 = 26'h0000C10;
        tick();
        total++; if (bus.pc !== 32'h3040) begin bad++; $display("FAIL j_over_br: got %h want %h", bus.pc, 32'h3040); end
        clr();
    endtask

    task automatic test_stall_pending();
        bus.jr_req = 1'b1; bus.jr_target = 32'h3020;
        tick(); clr();
        total++; if (bus.pc !== 32'h3020) begin bad++; $display("FAIL stl_setup: got %h want %h", bus.pc, 32'h3020); end
        bus.stall = 1'b1; bus.j_req = 1'b1; bus.j_addr26 = 26'h0000C20;
        #1;
        total++; if (bus.npc !== 32'h3020) begin bad++; $display("FAIL stl_npc: got %h want %h", bus.npc, 32'h3020); end
        tick();
        total++; if (bus.pc !== 32'h3020 || bus.pend_valid !== 1'b1) begin bad++; $display("FAIL stl_c1: got pc=%h pv=%b want 3020/1", bus.pc, bus.pend_valid); end
        bus.j_req = 1'b0; bus.exc_req = 1'b1;
        tick(); clr();
        total++; if (bus.pc !== 32'h3020 || bus.pend_valid !== 1'b1) begin bad++; $display("FAIL stl_c2: got pc=%h pv=%b want 3020/1", bus.pc, bus.pend_valid); end
        #1;
        total++; if (bus.npc !== 32'h4180) begin bad++; $display("FAIL stl_rel_npc: got %h want %h", bus.npc, 32'h4180); end
        tick();
        total++; if (bus.pc !== 32'h4180 || bus.pend_valid !== 1'b0) begin bad++; $display("FAIL stl_rel: got pc=%h pv=%b want 4180/0", bus.pc, bus.pend_valid); end
        // lower class must not displace a pending jr
        bus.stall = 1'b1; bus.jr_req = 1'b1; bus.jr_target = 32'h5000;
        tick();
        bus.jr_req = 1'b0; bus.br_taken = 1'b1; bus.br_off16 = 16'h0004;
        tick(); clr();
        tick();
        total++; if (bus.pc !== 32'h5000) begin bad++; $display("FAIL stl_lower: got %h want %h", bus.pc, 32'h5000); end
        // equal class at release: pending wins
        bus.stall = 1'b1; bus.j_req = 1'b1; bus.j_addr26 = 26'h0001000;
        tick();
        bus.stall = 1'b0; bus.j_addr26 = 26'h0001100;
        tick(); clr();
        total++; if (bus.pc !== 32'h4000) begin bad++; $display("FAIL stl_tie: got %h want %h", bus.pc, 32'h4000); end
        // higher live request beats pending
        bus.stall = 1'b1; bus.br_taken = 1'b1; bus.br_off16 = 16'h0010;
        tick(); clr();
        bus.jr_req = 1'b1; bus.jr_target = 32'h6000;
        tick(); clr();
        total++; if (bus.pc !== 32'h6000) begin bad++; $display("FAIL stl_live_hi: got %h want %h", bus.pc, 32'h6000); end
    endtask

    task automatic test_halt();
        int errs;
        bus.jr_req = 1'b1; bus.jr_target = 32'h4178;
        tick(); clr();
        tick();
        total++; if (bus.pc !== 32'h417C || bus.halted !== 1'b1) begin bad++; $display("FAIL halt_enter: got pc=%h h=%b want 417c/1", bus.pc, bus.halted); end
        errs = 0;
        for (int i = 0; i < 10; i++) begin
            bus.exc_req = 1'b1; bus.jr_req = 1'b1; bus.jr_target = 32'h7000;
            bus.stall = i[0]; bus.ras_push = 1'b1;
            tick();
            if (bus.pc !== 32'h417C || bus.npc !== 32'h417C || bus.pend_valid !== 1'b0 || bus.ras_count !== 3'd0) begin
                errs++;
                $display("FAIL halt_hold%0d: got pc=%h npc=%h pv=%b cnt=%0d want 417c/417c/0/0", i, bus.pc, bus.npc, bus.pend_valid, bus.ras_count);
            end
        end
        total++; if (errs != 0) bad++;
        clr();
        #2;
        reset = 1'b0;
        #1;
        total++; if (bus.pc !== 32'h3000 || bus.halted !== 1'b0) begin bad++; $display("FAIL halt_reset: got pc=%h h=%b want 3000/0", bus.pc, bus.halted); end
        reset = 1'b1;
    endtask

    task automatic test_ras();
        logic [2:0]  ecnt [5] = '{3'd3, 3'd2, 3'd1, 3'd0, 3'd0};
        logic [31:0] etop [5] = '{32'h3010, 32'h300C, 32'h3008, 32'h0, 32'h0};
        bus.ras_push = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        total++; if (bus.ras_count !== 3'd4 || bus.ras_top !== 32'h3014) begin bad++; $display("FAIL ras_fill: got cnt=%0d top=%h want 4/3014", bus.ras_count, bus.ras_top); end
        bus.ras_push = 1'b0; bus.ras_pop = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++; if (bus.ras_count !== ecnt[i] || bus.ras_top !== etop[i]) begin bad++; $display("FAIL ras_pop%0d: got cnt=%0d top=%h want %0d/%h", i, bus.ras_count, bus.ras_top, ecnt[i], etop[i]); end
        end
        total++; if (bus.ras_empty !== 1'b1 || bus.pc !== 32'h3028) begin bad++; $display("FAIL ras_empty: got e=%b pc=%h want 1/3028", bus.ras_empty, bus.pc); end
        bus.ras_push = 1'b1;
        tick();
        total++; if (bus.ras_count !== 3'd1 || bus.ras_top !== 32'h302C) begin bad++; $display("FAIL ras_pp_empty: got cnt=%0d top=%h want 1/302c", bus.ras_count, bus.ras_top); end
        tick();
        total++; if (bus.ras_count !== 3'd1 || bus.ras_top !== 32'h3030) begin bad++; $display("FAIL ras_pp: got cnt=%0d top=%h want 1/3030", bus.ras_count, bus.ras_top); end
        bus.ras_pop = 1'b0; bus.stall = 1'b1;
        tick(); clr();
        total++; if (bus.pc !== 32'h3030 || bus.ras_count !== 3'd2 || bus.ras_top !== 32'h3034) begin bad++; $display("FAIL ras_stall: got pc=%h cnt=%0d top=%h want 3030/2/3034", bus.pc, bus.ras_count, bus.ras_top); end
    endtask

    task automatic test_redirects();
        bus.jr_req = 1'b1; bus.jr_target = 32'h3002;
        tick(); clr();
        total++; if (bus.pc !== 32'h3002 || bus.misaligned !== 1'b1) begin bad++; $display("FAIL jr_mis: got pc=%h m=%b want 3002/1", bus.pc, bus.misaligned); end
        bus.eret_req = 1'b1; bus.epc = 30'h0000_0C05;
        tick(); clr();
        total++; if (bus.pc !== 32'h3014 || bus.misaligned !== 1'b0) begin bad++; $display("FAIL eret: got pc=%h m=%b want 3014/0", bus.pc, bus.misaligned); end
        bus.exc_req = 1'b1; bus.eret_req = 1'b1; bus.epc = 30'h0000_0C05; bus.jr_req = 1'b1;
        bus.jr_target = 32'h3100; bus.j_req = 1'b1; bus.br_taken = 1'b1;
        tick();
        total++; if (bus.pc !== 32'h4180) begin bad++; $display("FAIL pri_exc: got %h want %h", bus.pc, 32'h4180); end
        bus.exc_req = 1'b0;
        tick();
        total++; if (bus.pc !== 32'h3014) begin bad++; $display("FAIL pri_eret: got %h want %h", bus.pc, 32'h3014); end
        bus.eret_req = 1'b0;
        tick();
        total++; if (bus.pc !== 32'h3100) begin bad++; $display("FAIL pri_jr: got %h want %h", bus.pc, 32'h3100); end
        bus.jr_req = 1'b0; bus.j_addr26 = 26'h0000C10;
        tick(); clr();
        total++; if (bus.pc !== 32'h3040) begin bad++; $display("FAIL pri_j: got %h want %h", bus.pc, 32'h3040); end
    endtask

    task automatic test_reset_mid_stall();
        bus.stall = 1'b1; bus.exc_req = 1'b1;
        tick();
        total++; if (bus.pend_valid !== 1'b1) begin bad++; $display("FAIL rms_pend: got %b want 1", bus.pend_valid); end
        #2;
        reset = 1'b0;
        #1;
        total++; if (bus.pc !== 32'h3000 || bus.pend_valid !== 1'b0) begin bad++; $display("FAIL rms_async: got pc=%h pv=%b want 3000/0", bus.pc, bus.pend_valid); end
        clr();
        reset = 1'b1;
        tick();
        total++; if (bus.pc !== 32'h3004 || bus.pend_valid !== 1'b0) begin bad++; $display("FAIL rms_after: got pc=%h pv=%b want 3004/0", bus.pc, bus.pend_valid); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_sequential();
        test_branch_jump();
        test_stall_pending();
        test_halt();
        test_ras();
        test_redirects();
        test_reset_mid_stall();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fetch_pc_unit.md
FETCH_PC_UNIT -- requirements
Module: fetch_pc_unit

Interface
REQ-001 Parameter ADDR_W, default 32: PC/target width, minimum 32.
REQ-002 Parameter RESET_VEC, default 32'h0000_3000: PC after reset.
REQ-003 Parameter KTEXT_VEC, default 32'h0000_4180: exception handler entry.
REQ-004 Parameter HALT_ADDR, default KTEXT_VEC-4: terminal PC.
REQ-005 Parameter RAS_DEPTH, default 4: return-address-stack entries, power of two, 2..16.
REQ-006 clk  in  1  single clock; all state updates on rising edge.
REQ-007 reset  in  1  asynchronous, active-low reset.
REQ-008 stall  in  1  hold PC this cycle.
REQ-009 exc_req  in  1  exception/interrupt redirect to KTEXT_VEC.
REQ-010 eret_req  in  1  return to {epc, 2'b00}.
REQ-011 epc  in  ADDR_W-2  exception return address bits [ADDR_W-1:2].
REQ-012 jr_req  in  1  register jump (JR/JALR) to jr_target.
REQ-013 jr_target  in  ADDR_W  register jump target.
REQ-014 j_req  in  1  immediate jump (J/JAL).
REQ-015 j_addr26  in  26  jump index.
REQ-016 br_taken  in  1  resolved taken branch.
REQ-017 br_off16  in  16  branch word offset.
REQ-018 ras_push  in  1  call retired in decode (JAL/JALR); push pc+4 (link = branch PC+8).
REQ-019 ras_pop  in  1  return (JR $ra) in decode.
REQ-020 pc  out  ADDR_W  current fetch PC (registered).
REQ-021 npc  out  ADDR_W  next PC (combinational).
REQ-022 halted  out  1  pc == HALT_ADDR.
REQ-023 pend_valid  out  1  redirect latched during stall.
REQ-024 misaligned  out  1  pc[1:0] != 0.
REQ-025 ras_top  out  ADDR_W  top-of-stack value, 0 when empty.
REQ-026 ras_empty  out  1  stack count == 0.
REQ-027 ras_count  out  clog2(RAS_DEPTH)+1  valid entries.

Function
REQ-028 Targets: branch = pc + sext({br_off16,2'b00}) mod 2^ADDR_W (pc is delay-slot PC); jump = {pc[ADDR_W-1:28], j_addr26, 2'b00}; eret = {epc,2'b00}; jr = jr_target unmodified.
REQ-029 Live priority, highest first: exc_req, eret_req, jr_req, j_req, br_taken, sequential pc+4.
REQ-030 halted=1 overrides all: npc = pc, pending cleared, PC frozen until reset.
REQ-031 stall=1, not halted: pc holds; highest live request (if any) latched into pending register (target + 3-bit priority class) when no pending exists or its class is higher-or-equal to pending's.
REQ-032 stall=0, not halted: npc = target of higher-class of {pending, live request}, pending wins ties; else pc+4; pending cleared same edge.
REQ-033 pend_valid reflects pending register; pending target computed at latch time (uses pc at request).
REQ-034 RAS: circular buffer, RAS_DEPTH entries, top pointer wraps modulo RAS_DEPTH.
REQ-035 Push only: write pc+4 at top+1, advance top, count saturates at RAS_DEPTH (oldest overwritten).
REQ-036 Pop only: retreat top, decrement count; pop when empty ignored (count stays 0, pointer unchanged).
REQ-037 Push+pop same cycle: overwrite top entry with pc+4, count unchanged; if empty, treated as push.
REQ-038 RAS updates regardless of stall; frozen when halted.
REQ-039 misaligned is informational only; PC loads misaligned targets as-is.

Reset
REQ-040 reset low: pc=RESET_VEC, pending cleared, RAS count=0, top pointer=0, entries=0, immediately and asynchronously.
REQ-041 Deassertion: first fetch at RESET_VEC; first update on next rising edge after release.
REQ-042 Reset mid-stall discards pending redirect.

Verification
REQ-043 Release reset, no requests, 3 cycles -> pc 3000, 3004, 3008, 300C.
REQ-044 pc=3010, br_taken, br_off16=16'hFFFC -> next pc 3000; j_addr26=26'h0000C10 same cycle with br_taken -> pc 3040.
REQ-045 stall 2 cycles at pc=3020 with j_req (addr 0x0C20) first cycle, exc_req second -> pend_valid=1, pc held 3020; on release pc=4180, pend_valid=0.
REQ-046 pc reaches 417C (HALT_ADDR) -> halted=1, pc stays 417C for 10 cycles despite exc_req/jr_req.
REQ-047 RAS_DEPTH=4: 5 pushes at pcs 3000..3010 -> ras_count=4, ras_top=3014; 5 pops -> count 0, ras_empty=1, fifth pop no effect; push+pop on empty -> count 1.
REQ-048 jr_req with jr_target=3002 -> pc=3002, misaligned=1; eret_req epc=30'h0000_0C05 -> pc=3014.
